// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: walks the operands one CHUNK at a time,
// most-significant chunk first, and finishes on the first chunk that differs.
// Signed operands are handled by flipping the MSB on capture, which turns a
// two's-complement compare into an unsigned one. Saturating counters keep
// statistics of greater/equal/less results.
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic             o_done,
  output logic [2:0]       o_f,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt_gt,
  output logic [CNT_W-1:0] o_cnt_eq,
  output logic [CNT_W-1:0] o_cnt_lt
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic signed [WIDTH-1:0] a_bias;
  logic signed [WIDTH-1:0] b_bias;
  logic [IDX_W-1:0]       idx;
  logic [CHUNK-1:0]       chunk_a;
  logic [CHUNK-1:0]       chunk_b;
  logic                   chunk_gt;
  logic                   chunk_lt;
  logic                   last_chunk;
  logic                   accept;
  logic                   decide;
  logic [2:0]             f_nxt;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v,
                                            input logic             sgn);
    return {v[WIDTH-1] ^ sgn, v[WIDTH-2:0]};
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign o_ready    = (state == IDLE);
  assign o_done     = (state == DONE);
  assign accept     = o_ready & i_valid;
  assign chunk_gt   = (chunk_a > chunk_b);
  assign chunk_lt   = (chunk_a < chunk_b);
  assign last_chunk = (idx == '0);

  // Select the chunk pair currently under comparison.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_a = a_bias[i*CHUNK +: CHUNK];
        chunk_b = b_bias[i*CHUNK +: CHUNK];
      end
    end
  end

  // Next-state and result decision.
  always_comb begin
    state_nxt = state;
    f_nxt     = o_f;
    decide    = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) state_nxt = CMP;
      end
      CMP: begin
        if (chunk_gt) begin
          f_nxt     = F_GT;
          decide    = 1'b1;
          state_nxt = DONE;
        end else if (chunk_lt) begin
          f_nxt     = F_LT;
          decide    = 1'b1;
          state_nxt = DONE;
        end else if (last_chunk) begin
          f_nxt     = F_EQ;
          decide    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand capture and chunk index walk-down.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_bias <= '0;
      b_bias <= '0;
      idx    <= '0;
    end else if (accept) begin
      a_bias <= bias(i_a, i_signed);
      b_bias <= bias(i_b, i_signed);
      idx    <= IDX_W'(N - 1);
    end else if (state == CMP && !decide) begin
      idx <= idx - 1'b1;
    end
  end

  // Result register; only changes on the edge that enters DONE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_f <= 3'b000;
    else       o_f <= f_nxt;
  end

  // Result counters; clear wins over a coincident increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt_gt <= '0;
      o_cnt_eq <= '0;
      o_cnt_lt <= '0;
    end else if (i_clr) begin
      o_cnt_gt <= '0;
      o_cnt_eq <= '0;
      o_cnt_lt <= '0;
    end else if (decide) begin
      if (f_nxt == F_GT) o_cnt_gt <= sat_inc(o_cnt_gt);
      if (f_nxt == F_EQ) o_cnt_eq <= sat_inc(o_cnt_eq);
      if (f_nxt == F_LT) o_cnt_lt <= sat_inc(o_cnt_lt);
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq: two instances sharing stimulus (8-bit and 2-bit
// counters), a transaction-level reference model, a per-cycle compare
// process and directed vectors with literal expectations.
module tb_comparator_seq;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sgn;
  logic         clr;

  logic         rdy8, done8, rdy2, done2;
  logic [2:0]   f8, f2;
  logic [7:0]   gt8, eq8, lt8;
  logic [1:0]   gt2, eq2, lt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  comparator_seq #(.WIDTH(W), .CHUNK(C), .CNT_W(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy8),
    .i_a(a), .i_b(b), .i_signed(sgn), .o_done(done8), .o_f(f8),
    .i_clr(clr), .o_cnt_gt(gt8), .o_cnt_eq(eq8), .o_cnt_lt(lt8));

  comparator_seq #(.WIDTH(W), .CHUNK(C), .CNT_W(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy2),
    .i_a(a), .i_b(b), .i_signed(sgn), .o_done(done2), .o_f(f2),
    .i_clr(clr), .o_cnt_gt(gt2), .o_cnt_eq(eq2), .o_cnt_lt(lt2));

  function automatic void chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Reference: result from plain integer comparison, chunk count from the
  // position of the highest differing bit.
  function automatic void predict(input logic [W-1:0] pa, input logic [W-1:0] pb,
                                  input logic ps, output logic [2:0] pf,
                                  output int pk);
    logic [W-1:0] d;
    int hi;
    d  = pa ^ pb;
    hi = -1;
    for (int i = 0; i < W; i++) if (d[i]) hi = i;
    pk = (hi < 0) ? N : N - hi / C;
    if (ps) pf = ($signed(pa) > $signed(pb)) ? 3'b100 :
                 ($signed(pa) < $signed(pb)) ? 3'b001 : 3'b010;
    else    pf = (pa > pb) ? 3'b100 : (pa < pb) ? 3'b001 : 3'b010;
  endfunction

  // Model state: busy countdown, pending result and true result counts.
  logic       m_ready, m_done;
  logic [2:0] m_f, m_pend;
  int         m_left, c_gt, c_eq, c_lt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1; m_done = 1'b0; m_f = 3'b000; m_pend = 3'b000;
      m_left = 0; c_gt = 0; c_eq = 0; c_lt = 0;
    end else begin
      logic fin;
      fin = 1'b0;
      if (m_done) begin
        m_done  = 1'b0;
        m_ready = 1'b1;
      end else if (!m_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_f    = m_pend;
          fin    = 1'b1;
        end
      end else if (valid) begin
        predict(a, b, sgn, m_pend, m_left);
        m_ready = 1'b0;
      end
      if (clr) begin
        c_gt = 0; c_eq = 0; c_lt = 0;
      end else if (fin) begin
        if (m_pend == 3'b100) c_gt++;
        if (m_pend == 3'b010) c_eq++;
        if (m_pend == 3'b001) c_lt++;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready8", rdy8, m_ready);
      chk("done8", done8, m_done);
      chk("f8", f8, m_f);
      chk("gt8", gt8, sat(c_gt, 8));
      chk("eq8", eq8, sat(c_eq, 8));
      chk("lt8", lt8, sat(c_lt, 8));
      chk("ready2", rdy2, m_ready);
      chk("done2", done2, m_done);
      chk("f2", f2, m_f);
      chk("gt2", gt2, sat(c_gt, 2));
      chk("eq2", eq2, sat(c_eq, 2));
      chk("lt2", lt2, sat(c_lt, 2));
    end
  end

  // One transaction: latency counted in cycles after the accept edge until
  // o_done is seen; clr_n asserts i_clr in that cycle (0 = never).
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [2:0] ef, input int elat,
                        input int clr_n, input string nm);
    int n;
    int w;
    w = 0;
    while (!rdy8 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready"}, rdy8, 1);
    a = ta; b = tb; sgn = ts; valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      valid = 1'b0;
      n++;
      clr = (n == clr_n);
    end while (!done8 && n < 20);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_f"}, f8, ef);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int         nd;
    logic [2:0] fs [3];
    valid = 1'b0; a = '0; b = '0; sgn = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", rdy8, 1);
    chk("rst_done", done8, 0);
    chk("rst_f", f8, 0);
    chk("rst_cnt", {gt8, eq8, lt8}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Early exit and full-length compares.
    do_cmp(16'h8000, 16'h0001, 1'b0, 3'b100, 2, 0, "early");
    chk("early_gt", gt8, 1);
    do_cmp(16'h1234, 16'h1234, 1'b0, 3'b010, 5, 0, "equal");
    chk("equal_eq", eq8, 1);
    do_cmp(16'h1235, 16'h1234, 1'b0, 3'b100, 5, 0, "lastchunk");

    // Sign mode.
    do_cmp(16'hFFFF, 16'h0001, 1'b1, 3'b001, 2, 0, "s_neg1");
    do_cmp(16'hFFFF, 16'h0001, 1'b0, 3'b100, 2, 0, "u_ffff");
    do_cmp(16'h8000, 16'h7FFF, 1'b1, 3'b001, 2, 0, "s_min");
    chk("tot_gt8", gt8, 3);
    chk("tot_eq8", eq8, 1);
    chk("tot_lt8", lt8, 2);
    chk("tot_gt2", gt2, 3);

    // Handshake: valid held high, operands change while busy.
    a = 16'h1235; b = 16'h1234; sgn = 1'b0; valid = 1'b1;
    nd = 0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      a = 16'h0000; b = 16'hFFFF;
      if (done8) begin
        if (nd < 3) fs[nd] = f8;
        nd++;
      end
    end
    valid = 1'b0;
    chk("hs_count", nd, 3);
    chk("hs_f0", fs[0], 3'b100);
    chk("hs_f1", fs[1], 3'b001);
    chk("hs_f2", fs[2], 3'b001);
    @(negedge clk);

    // Counter clear and saturation.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) do_cmp(16'hABCD, 16'hABCD, 1'b0, 3'b010, 5, 0, "sat");
    chk("sat_eq2", eq2, 3);
    chk("sat_eq8", eq8, 5);
    do_cmp(16'h0F0F, 16'h0F0F, 1'b1, 3'b010, 5, 5, "clr_done");
    chk("clr_done_eq", {gt8, eq8, lt8, gt2, eq2, lt2}, 0);
    chk("clr_done_f", f8, 3'b010);
    do_cmp(16'h0F0F, 16'h0F0F, 1'b0, 3'b010, 5, 4, "clr_inc");
    chk("clr_inc_eq", eq8, 0);

    // Reset in the second CMP cycle.
    a = 16'h1234; b = 16'h1234; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_ready", rdy8, 1);
    chk("mid_done", done8, 0);
    chk("mid_f", f8, 0);
    chk("mid_cnt", {gt8, eq8, lt8, gt2, eq2, lt2}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_ready", rdy8, 1);
    do_cmp(16'h0001, 16'h0002, 1'b0, 3'b001, 5, 0, "after_rst");
    chk("after_rst_lt", lt8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
# comparator_seq

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands CHUNK bits at a time, most-significant chunk first, and stops early on the first differing chunk. It supports signed and unsigned operands per transaction, uses a valid/ready input handshake, and keeps saturating counters of greater/equal/less results. It replaces the single-cycle 3-bit comparator wherever wide operands or result statistics are needed.

## Interface
- WIDTH, 16: operand width; must be a multiple of CHUNK.
- CHUNK, 4: bits compared per cycle; N = WIDTH/CHUNK chunks.
- CNT_W, 8: width of each result counter.

- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  operands present.
- o_ready  out  1  block accepts operands.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands.
- o_done  out  1  one-cycle pulse; o_f holds a new result.
- o_f  out  3  one-hot result: bit2 = A>B, bit1 = A==B, bit0 = A<B. 3'b000 = no result since reset.
- i_clr  in  1  synchronous clear of all counters.
- o_cnt_gt, o_cnt_eq, o_cnt_lt  out  CNT_W  saturating result counters.

## Operation
- **Reset values:**
  - state IDLE, o_ready=1, o_done=0, o_f=3'b000, all counters 0.
  - Internal operand registers and chunk index are cleared.
- **Bias rule:** operands are latched with MSB XOR i_signed. Signed compare then reduces to unsigned compare of the biased values.
- **FSM states:** IDLE, CMP, DONE.
- **IDLE:**
  - o_ready=1.
  - On i_valid & o_ready: latch biased i_a, i_b, set idx=N-1, go to CMP.
- **CMP:** o_ready=0. Each cycle compares chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK).
  - Chunk A > chunk B: load o_f=100, go to DONE.
  - Chunk A < chunk B: load o_f=010 is wrong; load o_f=001, go to DONE.
  - Chunks equal, idx=0: load o_f=010, go to DONE.
  - Chunks equal, idx>0: decrement idx, stay in CMP.
- **DONE:**
  - o_done=1, o_ready=0.
  - Next edge returns to IDLE.
- **o_f:** holds its value until the next DONE entry.
- **Counters:**
  - The counter matching the new o_f increments on the same edge that enters DONE, so it is already updated while o_done=1.
  - Each counter saturates at 2^CNT_W-1; it never wraps.
  - i_clr zeroes all counters and has priority over a coincident increment.
  - i_clr does not affect o_f or the FSM.
- **Handshake rules:**
  - i_valid while o_ready=0 is ignored; operands are not captured and nothing is queued.
  - Input changes during CMP/DONE do not affect the result in flight.

## Timing
- Accept on edge E0. With k chunks examined (1 ≤ k ≤ N):
  - result decided on edge Ek, entering DONE;
  - o_done high for the cycle after Ek;
  - o_ready high again after edge Ek+1.
- Latency from accept to o_done: k+1 cycles (min 2, max N+1).
- Throughput: one transaction per k+2 cycles.
- o_ready, o_done, o_f and the counters are registered or decoded from state only; there is no combinational path from any input to any output.
- **Reset mid-operation:** asserting i_rst in CMP or DONE aborts the transaction immediately.
  - No o_done is produced.
  - All outputs take their reset values asynchronously.
  - After reset is released, the block is in IDLE with o_ready=1 on the first edge.

## Test plan
1. Early exit, unsigned: WIDTH=16, CHUNK=4, i_signed=0, A=0x8000, B=0x0001 → o_f=100 with o_done 2 cycles after accept; o_cnt_gt=1.
2. Full-length equal: A=B=0x1234 → 4 CMP cycles, o_done 5 cycles after accept, o_f=010, o_cnt_eq=1. Last-chunk difference A=0x1235, B=0x1234 → o_f=100 after 5 cycles.
3. Sign mode: A=0xFFFF, B=0x0001 with i_signed=1 → o_f=001. Same operands with i_signed=0 → o_f=100. A=0x8000, B=0x7FFF with i_signed=1 → o_f=001.
4. Handshake: hold i_valid=1 with changing operands during CMP → exactly one result per o_ready window, computed from the latched operands; back-to-back accepts spaced k+2 cycles apart.
5. Counters: CNT_W=2, five equal compares → o_cnt_eq=3 (saturated). Assert i_clr in the same cycle as o_done → all counters 0 on the next cycle, while o_f keeps 010.
6. Reset mid-operation: assert i_rst during the second CMP cycle → o_done never pulses, o_f=000, counters 0, o_ready=1. A new compare after release completes normally.
